// File: rtl/rv_pkg.sv
// Shared types for the instruction fetch slice: widths, fetch FSM states and
// the prefetch queue entry.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_prefetch_if.sv
// Memory request/response and decode channels of the fetch unit.
// master = fetch unit side, slave = memory/decode side.
interface ifetch_prefetch_if;
  import rv_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            dec_valid;
  logic [ILEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            dec_fault;
  logic            dec_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_valid, dec_instr, dec_pc, dec_fault,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_valid, dec_instr, dec_pc, dec_fault,
    output dec_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of fetch entries with flush.
// Head is read straight from storage, so a write shows up the next cycle.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  fetch_entry_t                 wr_data,
  input  logic                         rd_en,
  output fetch_entry_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A write into a full queue is legal when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch unit with prefetch queue, in-order memory requests and
// redirect flush. Optional misaligned-redirect fault entry: IFETCH_ALIGN_CHECK_EN.
module ifetch_prefetch
  import rv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  ifetch_prefetch_if.master bus
);
  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d;
  logic            started_q, started_d;
  fetch_state_e    state_q, state_d;

  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            fifo_empty, unused_fifo_full;
  fetch_entry_t    fifo_head, head, enq_entry;
  logic            req_fire, rsp_drop, enq, deq, dec_valid_w;
  logic [XLEN-1:0] redir_pc;
  logic            redir_bad;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_vld_q, fault_vld_d;

  assign redir_pc  = redirect_pc;
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
  assign redir_bad        = 1'b0;
`endif

  // Queue occupancy plus outstanding requests never exceeds DEPTH, so every
  // response has a slot waiting for it.
  assign used               = {1'b0, count} + {1'b0, inflight_q};
  assign bus.imem_req_valid = started_q && (state_q == FETCH) && !redirect_valid
                              && (used < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc_q;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop  = (drop_q != '0);
  assign enq       = bus.imem_rsp_valid && !rsp_drop && !redirect_valid && (state_q == FETCH);
  assign deq       = dec_valid_w && bus.dec_ready && !redirect_valid;
  assign enq_entry = '{instr: bus.imem_rsp_data, pc: rsp_pc_q, fault: 1'b0};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    state_d    = state_q;
    started_d  = 1'b1;
    if (redirect_valid) begin
      // Everything still outstanding (minus the response consumed now) is stale.
      inflight_d = inflight_q - CW'(bus.imem_rsp_valid);
      drop_d     = inflight_q - CW'(bus.imem_rsp_valid);
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      state_d    = redir_bad ? FAULT : FETCH;
    end else begin
      inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && rsp_drop) drop_d = drop_q - CW'(1);
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (enq)      rsp_pc_d   = rsp_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      state_q    <= FETCH;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      started_q  <= started_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_data (enq_entry),
    .rd_en   (deq),
    .rd_data (fifo_head),
    .count   (count),
    .full    (unused_fifo_full),
    .empty   (fifo_empty)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  // In FAULT the queue is empty; the marker entry reuses rsp_pc, which holds
  // the faulting redirect target since nothing is enqueued.
  assign dec_valid_w = (state_q == FAULT) ? fault_vld_q : !fifo_empty;
  assign head        = (state_q == FAULT) ? '{instr: '0, pc: rsp_pc_q, fault: 1'b1} : fifo_head;
  assign fault_vld_d = redirect_valid ? redir_bad : (fault_vld_q && !deq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_vld_q <= 1'b0;
    else      fault_vld_q <= fault_vld_d;
  end
`else
  assign dec_valid_w = !fifo_empty;
  assign head        = fifo_head;
`endif

  assign bus.dec_valid = dec_valid_w;
  assign bus.dec_instr = dec_valid_w ? head.instr : '0;
  assign bus.dec_pc    = dec_valid_w ? head.pc : '0;
  assign bus.dec_fault = dec_valid_w && head.fault;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: cycle table from reset, then redirect,
// memory-stall, wrap, alignment and mid-operation reset sequences.
module tb_ifetch_prefetch;
  import rv_pkg::*;

  logic        clk, rst, redirect_valid;
  logic [31:0] redirect_pc;

  ifetch_prefetch_if bus();

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    bit          dr;
    bit          mr;
    bit          ev;
    logic [31:0] ea;
    bit          dv;
    logic [31:0] dp;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  vec_t        tbl [20];
  pend_t       pend [$];
  int          checks, errors, cyc, lat, deq_cnt;
  bit          chk_on;
  logic [31:0] exp_pc, exp_req;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, expv);
    end
  endfunction

  // One clock: stream checks before the edge, memory model (in order,
  // lat-cycle response, data = ~addr) after it.
  task automatic step();
    bit          acc, took;
    logic [31:0] a;
    #1;
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    a    = bus.imem_req_addr;
    took = bus.imem_rsp_valid;
    if (chk_on) begin
      if (acc) begin
        chk("stream_req_addr", a, exp_req);
        exp_req += 32'd4;
      end
      if (bus.dec_valid && bus.dec_ready && !redirect_valid) begin
        chk("stream_dec_pc", bus.dec_pc, exp_pc);
        chk("stream_dec_instr", bus.dec_instr, ~exp_pc);
        exp_pc += 32'd4;
        deq_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (took && pend.size() > 0) pend.delete(0);
    if (acc) pend.push_back('{a, cyc + lat - 1});
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = ~pend[0].addr;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst                = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.dec_ready      = 1'b1;
    chk_on             = 1'b0;
    pend.delete();
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_dec_fault", bus.dec_fault, 0);
    chk("rst_dec_pc", bus.dec_pc, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    chk("redir_blocks_req", bus.imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    exp_pc         = pc & 32'hFFFF_FFFC;
    exp_req        = pc & 32'hFFFF_FFFC;
    deq_cnt        = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lat    = 1;
    // Cycle table from reset release: 1-cycle memory, decode stalls c5..c14.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
    for (int i = 7; i < 15; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    rst = 1'b1;
    #2;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      bus.dec_ready      = tbl[i].dr;
      bus.imem_req_ready = tbl[i].mr;
      #1;
      chk($sformatf("t%0d_req_valid", i), bus.imem_req_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("t%0d_req_addr", i), bus.imem_req_addr, tbl[i].ea);
      chk($sformatf("t%0d_dec_valid", i), bus.dec_valid, tbl[i].dv);
      chk($sformatf("t%0d_dec_pc", i), bus.dec_pc, tbl[i].dp);
      chk($sformatf("t%0d_dec_instr", i), bus.dec_instr, tbl[i].dv ? ~tbl[i].dp : 32'h0);
      chk($sformatf("t%0d_dec_fault", i), bus.dec_fault, 0);
      step();
    end

    // Redirect while a response arrives and the head is being dequeued.
    redirect_to(32'h200);
    #1;
    chk("B_flush_empty", bus.dec_valid, 0);
    chk("B_req_valid", bus.imem_req_valid, 1);
    chk("B_req_addr", bus.imem_req_addr, 32'h200);
    chk_on = 1'b1;
    step();
    #1;
    chk("B_dec_n2", bus.dec_valid, 0);
    step();
    #1;
    chk("B_dec_n3_valid", bus.dec_valid, 1);
    chk("B_dec_n3_pc", bus.dec_pc, 32'h200);
    repeat (4) step();
    chk("B_deq_cnt", deq_cnt, 4);

    // Memory not ready for 5 cycles: request held, nothing duplicated.
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("C_hold_valid", bus.imem_req_valid, 1);
      chk("C_hold_addr", bus.imem_req_addr, exp_req);
      step();
    end
    bus.imem_req_ready = 1'b1;
    deq_cnt = 0;
    repeat (8) step();
    chk("C_resume_deq_cnt", deq_cnt, 6);

    // PC wrap across 2^32.
    redirect_to(32'hFFFF_FFF8);
    #1;
    chk("E_req_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
    repeat (9) step();
    chk("E_deq_cnt", deq_cnt, 7);
    chk("E_exp_pc_wrapped", exp_pc, 32'h14);

`ifdef IFETCH_ALIGN_CHECK_EN
    chk_on         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    chk("F_redir_blocks_req", bus.imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    bus.dec_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("F_fault_valid", bus.dec_valid, 1);
      chk("F_fault_flag", bus.dec_fault, 1);
      chk("F_fault_pc", bus.dec_pc, 32'h102);
      chk("F_fault_instr", bus.dec_instr, 0);
      chk("F_no_req", bus.imem_req_valid, 0);
      step();
    end
    bus.dec_ready = 1'b1;
    step();
    #1;
    chk("F_fault_consumed", bus.dec_valid, 0);
    chk("F_still_no_req", bus.imem_req_valid, 0);
    chk_on = 1'b1;
    redirect_to(32'h200);
    #1;
    chk("F_resume_valid", bus.imem_req_valid, 1);
    chk("F_resume_addr", bus.imem_req_addr, 32'h200);
    repeat (4) step();
    chk("F_resume_deq_cnt", deq_cnt, 2);
`else
    redirect_to(32'h102);
    #1;
    chk("F_aligned_addr", bus.imem_req_addr, 32'h100);
    repeat (4) step();
    chk("F_deq_cnt", deq_cnt, 2);
    #1;
    chk("F_dec_valid", bus.dec_valid, 1);
    chk("F_dec_fault", bus.dec_fault, 0);
`endif

    // Reset in the middle of streaming, then redirect with 2 requests in flight.
    do_reset();
    lat     = 3;
    exp_pc  = 32'h0;
    exp_req = 32'h0;
    deq_cnt = 0;
    chk_on  = 1'b1;
    repeat (3) step();
    redirect_to(32'h100);
    #1;
    chk("A_req_valid", bus.imem_req_valid, 1);
    chk("A_req_addr", bus.imem_req_addr, 32'h100);
    repeat (8) step();
    chk("A_deq_cnt", deq_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
